// File: rtl/cnt_rr_arbiter.sv
// Round-robin arbiter sharing one up/down/load counter among NREQ requesters.
// Grants may be locked for several ops, capped at MAX_HOLD cycles per tenure.
module cnt_rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 8,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int HW  = $clog2(MAX_HOLD) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ-1:0]       op_wr,
  input  logic [NREQ-1:0]       op_up,
  input  logic [NREQ*WIDTH-1:0] loadin,
  output logic [NREQ-1:0]       gnt,
  output logic [IDW-1:0]        gnt_id,
  output logic                  busy,
  output logic [WIDTH-1:0]      dout,
  output logic                  wrap
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [HW-1:0]    hold_cnt;
  logic [IDW-1:0]   base;
  logic [IDW-1:0]   win;
  logic             act;
  logic             rel;
  logic [WIDTH-1:0] ld;

  // First set bit after b, wrapping; b itself is scanned last.
  function automatic logic [IDW-1:0] pick(
    input logic [NREQ-1:0] r,
    input logic [IDW-1:0]  b
  );
    logic [IDW-1:0] w;
    int idx;
    w = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(b) + k) % NREQ;
      if (r[idx]) w = IDW'(idx);
    end
    return w;
  endfunction

  always_comb begin
    base = (state == GRANT) ? gnt_id : ptr;
    win  = pick(req, base);
    act  = req[gnt_id];
    rel  = !act || !lock[gnt_id] ||
           (hold_cnt == HW'(MAX_HOLD - 1));
    ld   = loadin[int'(gnt_id)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= IDW'(NREQ - 1);
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      dout     <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            gnt      <= NREQ'(1) << win;
            gnt_id   <= win;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (act) begin
            if (op_wr[gnt_id]) begin
              dout <= ld;
            end else if (op_up[gnt_id]) begin
              dout <= dout + WIDTH'(1);
              wrap <= (dout == '1);
            end else begin
              dout <= dout - WIDTH'(1);
              wrap <= (dout == '0);
            end
          end
          if (rel) begin
            ptr      <= gnt_id;
            hold_cnt <= '0;
            if (|req) begin
              gnt    <= NREQ'(1) << win;
              gnt_id <= win;
            end else begin
              state  <= IDLE;
              gnt    <= '0;
              gnt_id <= '0;
              busy   <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_rr_arbiter.sv
// Scoreboard bench for cnt_rr_arbiter against a tenure-level model.
// Stimulus pushes expected outputs; a monitor pops and compares.
module tb_cnt_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int MAXH  = 8;
  localparam int MOD   = 1 << WIDTH;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ-1:0]       op_wr;
  logic [NREQ-1:0]       op_up;
  logic [NREQ*WIDTH-1:0] loadin;
  logic [NREQ-1:0]       gnt;
  logic [1:0]            gnt_id;
  logic                  busy;
  logic [WIDTH-1:0]      dout;
  logic                  wrap;

  cnt_rr_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAXH)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .op_wr(op_wr), .op_up(op_up), .loadin(loadin),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy),
    .dout(dout), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0]  gnt;
    logic [1:0]       id;
    logic             busy;
    logic [WIDTH-1:0] dout;
    logic             wrap;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Model: who owns the counter, how many ops this tenure,
  // who owned it last, and the count itself.
  int owner = -1;
  int ops   = 0;
  int last  = NREQ - 1;
  int cnt   = 0;
  bit mwrap = 0;

  function automatic int rr(int from, logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(from + k) % NREQ]) return (from + k) % NREQ;
    return -1;
  endfunction

  task automatic model_step();
    bit released;
    int v;
    if (rst) begin
      owner = -1; ops = 0; last = NREQ - 1; cnt = 0; mwrap = 0;
      return;
    end
    mwrap = 0;
    if (owner < 0) begin
      owner = rr(last, req);
      ops = 0;
      return;
    end
    released = 0;
    if (!req[owner]) begin
      released = 1;
    end else begin
      if (op_wr[owner]) begin
        v = int'(loadin[owner*WIDTH +: WIDTH]);
        cnt = v;
      end else if (op_up[owner]) begin
        mwrap = (cnt == MOD - 1);
        cnt = (cnt + 1) % MOD;
      end else begin
        mwrap = (cnt == 0);
        cnt = (cnt + MOD - 1) % MOD;
      end
      ops++;
      if (!lock[owner] || ops == MAXH) released = 1;
    end
    if (released) begin
      last = owner;
      owner = rr(last, req);
      ops = 0;
    end
  endtask

  task automatic cyc(
    input logic r, input logic [NREQ-1:0] rq,
    input logic [NREQ-1:0] lk, input logic [NREQ-1:0] wr,
    input logic [NREQ-1:0] up, input logic [NREQ*WIDTH-1:0] li
  );
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; lock = lk;
    op_wr = wr; op_up = up; loadin = li;
    model_step();
    e.gnt  = (owner < 0) ? '0 : NREQ'(1) << owner;
    e.id   = (owner < 0) ? 2'd0 : 2'(owner);
    e.busy = (owner >= 0);
    e.dout = WIDTH'(cnt);
    e.wrap = mwrap;
    q.push_back(e);
  endtask

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt", int'(gnt), int'(e.gnt));
        chk("gnt_id", int'(gnt_id), int'(e.id));
        chk("busy", int'(busy), int'(e.busy));
        chk("dout", int'(dout), int'(e.dout));
        chk("wrap", int'(wrap), int'(e.wrap));
      end
    end
  end

  logic [NREQ*WIDTH-1:0] ffff;
  logic [NREQ*WIDTH-1:0] rnd;

  initial begin
    rst = 1'b1; req = '0; lock = '0;
    op_wr = '0; op_up = '0; loadin = '0;
    ffff = '0;
    ffff[2*WIDTH +: WIDTH] = 16'hFFFF;
    repeat (3) cyc(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, '0);
    // all requesting, single ops, counting up
    repeat (8) cyc(0, 4'b1111, 4'b0000, 4'b0000, 4'b1111, '0);
    repeat (2) cyc(0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, '0);
    // locked tenure hits the hold cap, req1 joins mid-tenure
    repeat (3) cyc(0, 4'b0001, 4'b0001, 4'b0000, 4'b1111, '0);
    repeat (9) cyc(0, 4'b0011, 4'b0001, 4'b0000, 4'b1111, '0);
    repeat (2) cyc(0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, '0);
    // load FFFF then increment to wrap
    cyc(0, 4'b0100, 4'b0000, 4'b0100, 4'b0100, ffff);
    cyc(0, 4'b0100, 4'b0100, 4'b0100, 4'b0100, ffff);
    cyc(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, ffff);
    repeat (2) cyc(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, '0);
    // decrement from zero wraps to max
    repeat (2) cyc(0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, '0);
    repeat (2) cyc(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, '0);
    // withdrawal mid-lock with and without another pending
    repeat (3) cyc(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, '0);
    repeat (2) cyc(0, 4'b0000, 4'b0010, 4'b0000, 4'b0010, '0);
    repeat (3) cyc(0, 4'b0001, 4'b0001, 4'b0000, 4'b1111, '0);
    repeat (3) cyc(0, 4'b1000, 4'b1111, 4'b0000, 4'b1111, '0);
    // reset mid-tenure with an op pending
    repeat (3) cyc(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, '0);
    cyc(1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, '0);
    repeat (3) cyc(0, 4'b1111, 4'b1111, 4'b0000, 4'b1111, '0);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rnd = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) rnd[WIDTH-1:0] = 16'hFFFF;
      if ($urandom_range(0, 7) == 0) rnd[WIDTH +: WIDTH] = '0;
      cyc(($urandom_range(0, 199) == 0),
          NREQ'($urandom()), NREQ'($urandom() | $urandom()),
          NREQ'($urandom() & $urandom() & $urandom()),
          NREQ'($urandom()), rnd);
    end
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, '0);
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
